// File: rtl/tmds_encoder_multi.sv
// Purpose: CHANNELS-lane TMDS symbol encoder covering control, video, guard-band and TERC4 data-island symbols.
// Latency: 2 clk_pix cycles from input sample to tmds in every mode. Stage 1 forms q_m; stage 2 does DC balance.
// Backpressure: none. One symbol per lane is accepted and produced on every clock.
//
// Ports:
//   clk_pix   - pixel clock; all state changes on its rising edge
//   rst_pix   - synchronous active-high reset; loads the mode-0/ctrl=00 symbol everywhere
//   mode      - 0 control, 1 video, 2 video guard band, 3 data island (TERC4)
//   data_in   - 8 bits per lane, video byte
//   ctrl_in   - 2 bits per lane, control pair
//   aux_in    - 4 bits per lane, TERC4 nibble
//   tmds      - 10 bits per lane, bit 0 is serialised first
//   disparity - 6 bits per lane, signed running disparity after the symbol on tmds
//
// Build option: define TMDS_ENCODER_MULTI_TERC4_EN to enable TERC4 coding in mode 3.
// Without it, mode 3 produces control symbols from ctrl_in and aux_in is ignored.
module tmds_encoder_multi #(
  parameter int CHANNELS = 3
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [1:0]              mode,
  input  logic [8*CHANNELS-1:0]   data_in,
  input  logic [2*CHANNELS-1:0]   ctrl_in,
  input  logic [4*CHANNELS-1:0]   aux_in,
  output logic [10*CHANNELS-1:0]  tmds,
  output logic [6*CHANNELS-1:0]   disparity
);

  localparam logic [1:0] MODE_CTRL   = 2'd0;
  localparam logic [1:0] MODE_VIDEO  = 2'd1;
  localparam logic [1:0] MODE_GUARD  = 2'd2;
`ifdef TMDS_ENCODER_MULTI_TERC4_EN
  localparam logic [1:0] MODE_ISLAND = 2'd3;
`endif
  localparam logic [9:0] SYM_RESET   = 10'h354;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] ct);
    logic [9:0] s;
    case (ct)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

`ifdef TMDS_ENCODER_MULTI_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
    endcase
    return s;
  endfunction
`else
  logic w_aux_unused;
  assign w_aux_unused = ^aux_in;
`endif

  // Mode is shared by all lanes and travels alongside stage-1 data.
  logic [1:0] r_s1_mode;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) r_s1_mode <= MODE_CTRL;
    else         r_s1_mode <= mode;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [9:0] GUARD_SYM = (c % 3 == 1) ? 10'h133 : 10'h2CC;

    logic [8:0]        w_qm;
    logic [9:0]        w_fix;
    logic [8:0]        r_qm;
    logic [9:0]        r_fix;
    logic [3:0]        w_n1;
    logic signed [5:0] w_diff;
    logic signed [5:0] w_q2;
    logic signed [5:0] w_cnt_nx;
    logic [9:0]        w_tmds_nx;
    logic [9:0]        r_tmds;
    logic signed [5:0] r_cnt;

    // Stage 1: q_m for video, and the fixed symbol for every other mode.
    always_comb begin
      w_qm = qm_encode(data_in[8*c +: 8]);
      case (mode)
        MODE_GUARD:  w_fix = GUARD_SYM;
`ifdef TMDS_ENCODER_MULTI_TERC4_EN
        MODE_ISLAND: w_fix = terc4_sym(aux_in[4*c +: 4]);
`endif
        default:     w_fix = ctrl_sym(ctrl_in[2*c +: 2]);
      endcase
    end

    always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
        r_qm  <= '0;
        r_fix <= SYM_RESET;
      end else begin
        r_qm  <= w_qm;
        r_fix <= w_fix;
      end
    end

    // Stage 2: DC balance. w_diff is N1-N0 of q_m[7:0], i.e. 2*N1-8.
    always_comb begin
      w_n1      = ones8(r_qm[7:0]);
      w_diff    = $signed({1'b0, w_n1, 1'b0}) - 6'sd8;
      w_q2      = r_qm[8] ? 6'sd2 : 6'sd0;
      w_tmds_nx = r_fix;
      w_cnt_nx  = '0;
      if (r_s1_mode == MODE_VIDEO) begin
        if ((r_cnt == 6'sd0) || (w_diff == 6'sd0)) begin
          w_tmds_nx = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
          w_cnt_nx  = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (((r_cnt > 6'sd0) && (w_diff > 6'sd0)) ||
                     ((r_cnt < 6'sd0) && (w_diff < 6'sd0))) begin
          w_tmds_nx = {1'b1, r_qm[8], ~r_qm[7:0]};
          w_cnt_nx  = r_cnt + w_q2 - w_diff;
        end else begin
          w_tmds_nx = {1'b0, r_qm[8], r_qm[7:0]};
          w_cnt_nx  = r_cnt + w_diff + w_q2 - 6'sd2;
        end
      end
    end

    always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
        r_tmds <= SYM_RESET;
        r_cnt  <= '0;
      end else begin
        r_tmds <= w_tmds_nx;
        r_cnt  <= w_cnt_nx;
      end
    end

    assign tmds[10*c +: 10]     = r_tmds;
    assign disparity[6*c +: 6]  = r_cnt;
  end

endmodule
